// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad calculator sequencer driving an external registered add/sub datapath
module calc_sequencer #(
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] alu_num1,
    output logic [15:0] alu_num2,
    output logic        alu_op,
    input  logic [16:0] alu_result,
    output logic [16:0] display_value,
    output logic        display_neg,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        ISSUE,
        WAIT,
        SHOW
    } state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    state_t      state_q, state_d;
    logic [15:0] acc_a_q, acc_a_d;
    logic [15:0] acc_b_q, acc_b_d;
    logic [2:0]  count_q, count_d;
    logic        op_q, op_d;
    logic [16:0] disp_q, disp_d;
    logic        neg_q, neg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        is_digit, is_op, is_eq, is_ce, can_take;
    logic [15:0] digit_ext;
    logic        cap_neg;

    assign is_digit  = key_valid && (key_code <= 4'd9);
    assign is_op     = key_valid && ((key_code == 4'hA) || (key_code == 4'hB));
    assign is_eq     = key_valid && (key_code == 4'hC);
    assign is_ce     = key_valid && (key_code == 4'hD);
    assign can_take  = (count_q < MAX_CNT);
    assign digit_ext = {12'd0, key_code};
    assign cap_neg   = op_q & alu_result[16];

    always_comb begin
        state_d = state_q;
        acc_a_d = acc_a_q;
        acc_b_d = acc_b_q;
        count_d = count_q;
        op_d    = op_q;
        disp_d  = disp_q;
        neg_d   = neg_q;
        done_d  = 1'b0;

        case (state_q)
            ENTER_A: begin
                if (is_digit) begin
                    if (can_take) begin
                        acc_a_d = acc_a_q * 16'd10 + digit_ext;
                        count_d = count_q + 3'd1;
                    end
                end else if (is_op) begin
                    op_d    = key_code[0];
                    acc_b_d = 16'd0;
                    count_d = 3'd0;
                    state_d = ENTER_B;
                end else if (is_ce) begin
                    acc_a_d = 16'd0;
                    count_d = 3'd0;
                end
            end
            ENTER_B: begin
                if (is_digit) begin
                    if (can_take) begin
                        acc_b_d = acc_b_q * 16'd10 + digit_ext;
                        count_d = count_q + 3'd1;
                    end
                end else if (is_op) begin
                    op_d = key_code[0];
                end else if (is_ce) begin
                    acc_b_d = 16'd0;
                    count_d = 3'd0;
                end else if (is_eq) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Datapath result became valid on the ISSUE->WAIT edge; latch it now.
                state_d = SHOW;
                done_d  = 1'b1;
                neg_d   = cap_neg;
                disp_d  = cap_neg ? (~alu_result + 17'd1) : alu_result;
            end
            SHOW: begin
                if (is_digit) begin
                    acc_a_d = digit_ext;
                    count_d = 3'd1;
                    state_d = ENTER_A;
                end else if (is_op && !neg_q) begin
                    // Chain: the positive result becomes the next left operand.
                    acc_a_d = disp_q[15:0];
                    op_d    = key_code[0];
                    acc_b_d = 16'd0;
                    count_d = 3'd0;
                    state_d = ENTER_B;
                end else if (is_ce) begin
                    acc_a_d = 16'd0;
                    count_d = 3'd0;
                    state_d = ENTER_A;
                end
            end
            default: begin
                state_d = ENTER_A;
            end
        endcase

        if (state_d == ENTER_A) begin
            disp_d = {1'b0, acc_a_d};
            neg_d  = 1'b0;
        end else if (state_d == ENTER_B) begin
            disp_d = {1'b0, acc_b_d};
            neg_d  = 1'b0;
        end

        busy_d = (state_d == ISSUE) || (state_d == WAIT);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ENTER_A;
            acc_a_q <= 16'd0;
            acc_b_q <= 16'd0;
            count_q <= 3'd0;
            op_q    <= 1'b0;
            disp_q  <= 17'd0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
            count_q <= count_d;
            op_q    <= op_d;
            disp_q  <= disp_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign alu_num1      = acc_a_q;
    assign alu_num2      = acc_b_q;
    assign alu_op        = op_q;
    assign display_value = disp_q;
    assign display_neg   = neg_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - scoreboard bench for calc_sequencer with a registered add/sub datapath model
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [15:0] alu_num1, alu_num2;
    logic        alu_op;
    logic [16:0] alu_result = 17'd0;
    logic [16:0] display_value;
    logic        display_neg, busy, done;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [16:0] val;
        logic        neg;
        int          at;
    } exp_t;
    exp_t sb_q[$];

    calc_sequencer #(.MAX_DIGITS(4)) dut (
        .clk          (clk),
        .clear        (clear),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .alu_num1     (alu_num1),
        .alu_num2     (alu_num2),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .display_value(display_value),
        .display_neg  (display_neg),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External datapath: registered result one clock after operands are sampled.
    always @(posedge clk)
        alu_result <= alu_op ? ({1'b0, alu_num1} - {1'b0, alu_num2})
                             : ({1'b0, alu_num1} + {1'b0, alu_num2});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result_value", 32'(display_value), 32'(e.val));
                check("result_neg", 32'(display_neg), 32'(e.neg));
                check("done_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic press_eq(input logic [16:0] val, input logic neg);
        exp_t e;
        press(4'hC);
        e.val = val;
        e.neg = neg;
        e.at  = cyc + 2;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0;
        check("rst_display", 32'(display_value), 0);
        check("rst_neg", 32'(display_neg), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_num1", 32'(alu_num1), 0);
        check("rst_num2", 32'(alu_num2), 0);
        check("rst_op", 32'(alu_op), 0);

        // 12 + 34 = 46
        press(4'd1); press(4'd2);
        check("track_a", 32'(display_value), 12);
        press(4'hA);
        check("num1_after_op", 32'(alu_num1), 12);
        check("display_after_op", 32'(display_value), 0);
        press(4'd3); press(4'd4);
        check("track_b", 32'(display_value), 34);
        press_eq(17'd46, 1'b0);
        check("busy_issue", 32'(busy), 1);
        idle(4);
        check("busy_show", 32'(busy), 0);

        // 5 - 9 = -4, then add ignored in SHOW with negative result
        do_clear();
        press(4'd5); press(4'hB); press(4'd9);
        press_eq(17'd4, 1'b1);
        idle(4);
        press(4'hA);
        check("neg_chain_ignored_val", 32'(display_value), 4);
        check("neg_chain_ignored_neg", 32'(display_neg), 1);
        press(4'd3);
        check("show_digit_restart", 32'(display_value), 3);
        press(4'hC);
        idle(3);
        check("eq_in_enter_a_ignored", 32'(display_value), 3);

        // digit limit, clear-entry, max sum
        do_clear();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        check("max_digits", 32'(display_value), 1234);
        press(4'hD);
        check("ce_a", 32'(display_value), 0);
        for (int i = 0; i < 4; i++) press(4'd9);
        press(4'hA);
        for (int i = 0; i < 4; i++) press(4'd9);
        press_eq(17'd19998, 1'b0);
        idle(4);

        // 7 + 3 = 10, chained + 5 = 15
        do_clear();
        press(4'd7); press(4'hA); press(4'd3);
        press_eq(17'd10, 1'b0);
        idle(4);
        press(4'hA);
        check("chain_num1", 32'(alu_num1), 10);
        press(4'd5);
        press_eq(17'd15, 1'b0);
        idle(4);

        // 0 - 9999
        do_clear();
        press(4'hB);
        for (int i = 0; i < 4; i++) press(4'd9);
        press_eq(17'd9999, 1'b1);
        idle(4);

        // op replaced in ENTER_B, reserved codes ignored: 8 - 2 = 6
        do_clear();
        press(4'd8); press(4'hA); press(4'hB); press(4'd2);
        press(4'hE); press(4'hF);
        check("reserved_ignored", 32'(display_value), 2);
        check("op_replaced", 32'(alu_op), 1);
        press_eq(17'd6, 1'b0);
        idle(4);

        // digits during ISSUE/WAIT ignored: 2 + 3 = 5
        do_clear();
        press(4'd2); press(4'hA); press(4'd3);
        press_eq(17'd5, 1'b0);
        press(4'd7); press(4'd8);
        idle(3);
        check("issue_wait_keys_ignored", 32'(display_value), 5);

        // clear-entry in ENTER_B: 5 + 2 = 7, then CE in SHOW
        do_clear();
        press(4'd5); press(4'hA); press(4'd7); press(4'hD); press(4'd2);
        press_eq(17'd7, 1'b0);
        idle(4);
        press(4'hD);
        check("ce_show", 32'(display_value), 0);

        // clear during WAIT aborts the operation
        do_clear();
        press(4'd4); press(4'hA); press(4'd4); press(4'hC);
        @(posedge clk);
        #1;
        check("busy_wait", 32'(busy), 1);
        do_clear();
        check("abort_display", 32'(display_value), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        idle(4);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL expose parameter MAX_DIGITS, default 4, meaning max decimal digits accepted per operand (legal range 1..4).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port clear  input  1  synchronous active-high reset.
REQ-004 SHALL have port key_valid  input  1  one-cycle key strobe.
REQ-005 SHALL have port key_code  input  4  0-9 digit, 0xA add, 0xB subtract, 0xC equals, 0xD clear-entry, 0xE/0xF reserved.
REQ-006 SHALL have port alu_num1  output  16  operand A to adder/subtractor datapath.
REQ-007 SHALL have port alu_num2  output  16  operand B to datapath.
REQ-008 SHALL have port alu_op  output  1  0 add, 1 subtract.
REQ-009 SHALL have port alu_result  input  17  datapath result, registered, valid one clock after operands/op are sampled.
REQ-010 SHALL have port display_value  output  17  magnitude shown to user.
REQ-011 SHALL have port display_neg  output  1  sign of displayed result.
REQ-012 SHALL have port busy  output  1  high in ISSUE and WAIT.
REQ-013 SHALL have port done  output  1  one-cycle result-captured pulse.

Function
REQ-014 SHALL implement states ENTER_A, ENTER_B, ISSUE, WAIT, SHOW; all outputs registered.
REQ-015 SHALL sample key_code only on clock edges where key_valid=1; reserved codes SHALL be ignored in every state.
REQ-016 Digit in ENTER_A/ENTER_B: if digit count < MAX_DIGITS, acc = acc*10 + digit and count++; else digit ignored.
REQ-017 ENTER_A: digit accumulates accA; add/sub stores op, clears accB and count, goes ENTER_B; equals ignored; clear-entry zeroes accA and count.
REQ-018 ENTER_B: digit accumulates accB; add/sub replaces stored op, accB unchanged; clear-entry zeroes accB and count; equals goes ISSUE.
REQ-019 alu_num1=accA, alu_num2=accB, alu_op=op SHALL be stable from entry to ISSUE through end of WAIT.
REQ-020 ISSUE lasts exactly one cycle, then WAIT; WAIT lasts exactly one cycle, captures alu_result on its closing edge, then SHOW.
REQ-021 Capture: display_neg = alu_op & alu_result[16]; display_value = two's-complement magnitude (17-bit) when display_neg=1, else alu_result.
REQ-022 done SHALL be 1 for exactly the first cycle of SHOW, else 0.
REQ-023 Keys in ISSUE/WAIT SHALL be ignored without side effects.
REQ-024 SHOW: digit restarts with accA=digit, count=1, ENTER_A; add/sub with display_neg=0 loads accA=display_value[15:0], stores op, clears accB, goes ENTER_B (chaining); add/sub with display_neg=1 ignored; equals ignored; clear-entry zeroes display and accA, goes ENTER_A.
REQ-025 display_value SHALL track accA in ENTER_A, accB in ENTER_B (display_neg=0), hold last value in ISSUE/WAIT.
REQ-026 Max result 9999+9999=19998 SHALL fit without wrap; 0-9999 SHALL show 9999, neg 1.

Reset
REQ-027 clear=1 at a rising edge SHALL force ENTER_A, accA=accB=0, counts 0, op=0, alu_num1/alu_num2/alu_op=0, display_value=0, display_neg=0, busy=0, done=0.
REQ-028 clear SHALL take priority over a simultaneous key_valid and SHALL abort ISSUE/WAIT; an in-flight alu_result SHALL be discarded.
REQ-029 No asynchronous behaviour; outputs SHALL be undefined-free from the first clear edge.

Verification
REQ-030 Keys 1,2,A,3,4,C -> with equals sampled at edge k, done=1 after edge k+2 for one cycle, display_value=46, display_neg=0.
REQ-031 Keys 5,B,9,C -> display_value=4, display_neg=1; subsequent A ignored, state stays SHOW.
REQ-032 Keys 1,2,3,4,5 -> display_value=1234; then A,9,9,9,9,C with accA=9999 preloaded -> 19998.
REQ-033 Keys 7,A,3,C then A,5,C -> first result 10, chained result 15, done pulses twice.
REQ-034 clear asserted in WAIT -> next cycle ENTER_A, display_value=0, busy=0, done never pulses.
REQ-035 key_valid with digits during ISSUE/WAIT and codes 0xE/0xF anywhere -> no state, accumulator or display change.
